// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared state encoding, fetch defaults and address helpers for the instruction fetch controller.
package instr_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] DEF_END_ADDR  = 32'd64;
  localparam logic [31:0] DEF_HALT_WORD = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_STEP   = 32'd4;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory port, decode slot handshake, redirect and status.
interface instr_fetch_ctrl_if;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halted;

  modport master (
    input  start, imem_data, instr_ready, branch_taken, branch_target,
    output imem_addr, instr, instr_pc, instr_valid, halted
  );

  modport slave (
    output start, imem_data, instr_ready, branch_taken, branch_target,
    input  imem_addr, instr, instr_pc, instr_valid, halted
  );
endinterface

// File: rtl/instr_fetch_ctrl_pc_reg.sv
// Program counter: clear to 0, word-aligned redirect, or step; priority clr > redirect > incr.
module pc_reg
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_STEP = DEF_PC_STEP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        incr,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= 32'd0;
    end else if (clr) begin
      pc <= 32'd0;
    end else if (redirect) begin
      pc <= align_word(target);
    end else if (incr) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch FSM feeding a one-entry decode slot; word at pc registered one edge after it is addressed.
// Slot holds while instr_valid && !instr_ready; a branch flushes the slot and wins over everything.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] END_ADDR  = DEF_END_ADDR,
  parameter logic [31:0] HALT_WORD = DEF_HALT_WORD,
  parameter logic [31:0] PC_STEP   = DEF_PC_STEP
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_ctrl_if.master bus
);

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        slot_free;
  logic        pc_clr, pc_redirect, pc_incr;
  logic        load, valid_clr;

  assign slot_free     = !bus.instr_valid || bus.instr_ready;
  assign bus.imem_addr = pc;
  assign bus.halted    = (state == HALT);

  pc_reg #(.PC_STEP(PC_STEP)) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .clr      (pc_clr),
    .redirect (pc_redirect),
    .target   (bus.branch_target),
    .incr     (pc_incr),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_clr      = 1'b0;
    pc_redirect = 1'b0;
    pc_incr     = 1'b0;
    load        = 1'b0;
    valid_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          pc_clr    = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (bus.branch_taken) begin
          pc_redirect = 1'b1;
          valid_clr   = 1'b1;
        end else if (slot_free) begin
          // End-of-program check comes first so the word past the program is never decoded.
          if (pc == END_ADDR || bus.imem_data == HALT_WORD) begin
            valid_clr = 1'b1;
            state_nxt = HALT;
          end else begin
            load    = 1'b1;
            pc_incr = 1'b1;
          end
        end
      end
      HALT: begin
        if (bus.start) begin
          pc_clr    = 1'b1;
          valid_clr = 1'b1;
          state_nxt = FETCH;
        end else if (bus.instr_ready) begin
          valid_clr = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.instr       <= 32'd0;
      bus.instr_pc    <= 32'd0;
      bus.instr_valid <= 1'b0;
    end else if (load) begin
      bus.instr       <= bus.imem_data;
      bus.instr_pc    <= pc;
      bus.instr_valid <= 1'b1;
    end else if (valid_clr) begin
      bus.instr_valid <= 1'b0;
    end
  end

endmodule
